// File: rtl/unidade_hazard_pkg.sv
// -----------------------------------------------------------------------------
// unidade_hazard_pkg
// Shared definitions for the pipeline hazard/forwarding unit:
//   - fwd_sel_t       : ALU-operand mux3 select encoding
//   - REG_BITS_PADRAO : default register-index width (32 regs, x0 hardwired 0)
//   - CONT_WIDTH_PADRAO : default width of the stall performance counter
//   - escolhe_fonte() : forwarding source priority (EX/MEM over MEM/WB)
// -----------------------------------------------------------------------------
package unidade_hazard_pkg;

    // Encoding follows the input order of the operand mux3; 2'b11 is never driven.
    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,  // value read from the register file
        FWD_MEMWB = 2'b01,  // result held in MEM/WB
        FWD_EXMEM = 2'b10   // result held in EX/MEM
    } fwd_sel_t;

    localparam int REG_BITS_PADRAO   = 5;
    localparam int CONT_WIDTH_PADRAO = 32;

    // The younger producer (in MEM) carries the most recent value of the
    // register, so it takes priority over the older one (in WB).
    function automatic fwd_sel_t escolhe_fonte(input logic hit_mem, input logic hit_wb);
        fwd_sel_t sel;
        sel = FWD_REG;
        if (hit_mem) begin
            sel = FWD_EXMEM;
        end else if (hit_wb) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/unidade_hazard.sv
// -----------------------------------------------------------------------------
// unidade_hazard
// Hazard/forwarding control for the 5-stage pipeline. Keeps a shadow copy of
// the register-usage info of the instructions in EX, MEM and WB, selects the
// forwarding source of both EX operands and detects load-use hazards (stalling
// PC and IF/ID while a bubble is inserted into ID/EX).
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   id_*              register usage of the instruction currently in ID
//   flush_ex          taken branch/jump resolved in EX this cycle
//   seletor_a/b       operand A/B forward select of the EX instruction
//   stall             load-use stall this cycle
//   pc_escreve        PC write enable (~stall)
//   if_id_escreve     IF/ID write enable (~stall)
//   id_ex_bolha       ID/EX loads a bubble (stall | flush_ex)
//   contador_stalls   saturating count of stall cycles
// -----------------------------------------------------------------------------
module unidade_hazard
    import unidade_hazard_pkg::*;
#(
    parameter int REG_BITS   = REG_BITS_PADRAO,
    parameter int CONT_WIDTH = CONT_WIDTH_PADRAO
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valido,
    input  logic [REG_BITS-1:0]   id_rs1,
    input  logic [REG_BITS-1:0]   id_rs2,
    input  logic                  id_usa_rs1,
    input  logic                  id_usa_rs2,
    input  logic [REG_BITS-1:0]   id_rd,
    input  logic                  id_escreve_reg,
    input  logic                  id_le_mem,
    input  logic                  flush_ex,
    output logic [1:0]            seletor_a,
    output logic [1:0]            seletor_b,
    output logic                  stall,
    output logic                  pc_escreve,
    output logic                  if_id_escreve,
    output logic                  id_ex_bolha,
    output logic [CONT_WIDTH-1:0] contador_stalls
);

    // Register-usage info of one in-flight instruction.
    typedef struct packed {
        logic                valido;
        logic [REG_BITS-1:0] rs1;
        logic [REG_BITS-1:0] rs2;
        logic                usa_rs1;
        logic                usa_rs2;
        logic [REG_BITS-1:0] rd;
        logic                escreve;
        logic                le_mem;
    } slot_t;

    slot_t                 id_slot;
    slot_t                 ex_q;
    slot_t                 mem_q;
    slot_t                 wb_q;
    logic [CONT_WIDTH-1:0] cont_q;

    // A slot produces register r only if it is a live instruction that writes
    // a non-zero destination equal to r; x0 is never forwarded.
    function automatic logic slot_match(
        input logic                valido,
        input logic                escreve,
        input logic [REG_BITS-1:0] rd,
        input logic [REG_BITS-1:0] r
    );
        return valido & escreve & (rd != '0) & (rd == r);
    endfunction

    assign id_slot = '{
        valido:  id_valido,
        rs1:     id_rs1,
        rs2:     id_rs2,
        usa_rs1: id_usa_rs1,
        usa_rs2: id_usa_rs2,
        rd:      id_rd,
        escreve: id_escreve_reg,
        le_mem:  id_le_mem
    };

    // ------------------------------------------------------------------
    // Forwarding selectors. A load sitting in MEM has no data yet at the
    // EX/MEM boundary, so it is never an EX/MEM source; in that case the
    // WB slot is still considered.
    // ------------------------------------------------------------------
    fwd_sel_t sel_a;
    fwd_sel_t sel_b;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        sel_a = FWD_REG;
        sel_b = FWD_REG;
        if (ex_q.valido && ex_q.usa_rs1) begin
            sel_a = escolhe_fonte(
                slot_match(mem_q.valido, mem_q.escreve, mem_q.rd, ex_q.rs1) & ~mem_q.le_mem,
                slot_match(wb_q.valido,  wb_q.escreve,  wb_q.rd,  ex_q.rs1));
        end
        if (ex_q.valido && ex_q.usa_rs2) begin
            sel_b = escolhe_fonte(
                slot_match(mem_q.valido, mem_q.escreve, mem_q.rd, ex_q.rs2) & ~mem_q.le_mem,
                slot_match(wb_q.valido,  wb_q.escreve,  wb_q.rd,  ex_q.rs2));
        end
    end

    assign seletor_a = sel_a;
    assign seletor_b = sel_b;

    // ------------------------------------------------------------------
    // Load-use detection. The load's data only appears at MEM/WB, so an
    // ID instruction reading it must wait one cycle. A flush in EX
    // discards the ID instruction, making the stall pointless.
    // ------------------------------------------------------------------
    logic usa_carga_rs1;
    logic usa_carga_rs2;

    assign usa_carga_rs1 = id_usa_rs1 & (id_rs1 == ex_q.rd);
    assign usa_carga_rs2 = id_usa_rs2 & (id_rs2 == ex_q.rd);

    assign stall = id_valido & ex_q.valido & ex_q.le_mem & (ex_q.rd != '0)
                 & (usa_carga_rs1 | usa_carga_rs2) & ~flush_ex;

    assign pc_escreve    = ~stall;
    assign if_id_escreve = ~stall;
    assign id_ex_bolha   = stall | flush_ex;

    // ------------------------------------------------------------------
    // Shadow pipeline of slots. A bubble only needs valido cleared; the
    // whole slot is zeroed for clean state visibility.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments make all three slots shift on the same edge using pre-edge values.
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= id_ex_bolha ? '0 : id_slot;
        end
    end

    // Saturating stall counter: holds at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cont_q <= '0;
        end else if (stall && (cont_q != '1)) begin
            cont_q <= cont_q + CONT_WIDTH'(1);
        end
    end

    assign contador_stalls = cont_q;

    // Source/load fields of the retiring WB slot are carried for debug
    // visibility only; forwarding consults just its destination fields.
    logic unused_wb;
    assign unused_wb = ^{wb_q.rs1, wb_q.rs2, wb_q.usa_rs1, wb_q.usa_rs2, wb_q.le_mem};

endmodule

// File: tb/tb_unidade_hazard.sv
// -----------------------------------------------------------------------------
// tb_unidade_hazard
// Directed scenarios plus randomized traffic for unidade_hazard. The reference
// model keeps the last three instructions that entered EX in a queue
// (index 0 = EX, 1 = MEM, 2 = WB) and derives the expected selectors, stall and
// counter straight from the forwarding/load-use rules.
// -----------------------------------------------------------------------------
module tb_unidade_hazard;

    localparam int RB = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valido;
    logic [RB-1:0] id_rs1;
    logic [RB-1:0] id_rs2;
    logic          id_usa_rs1;
    logic          id_usa_rs2;
    logic [RB-1:0] id_rd;
    logic          id_escreve_reg;
    logic          id_le_mem;
    logic          flush_ex;
    logic [1:0]    seletor_a;
    logic [1:0]    seletor_b;
    logic          stall;
    logic          pc_escreve;
    logic          if_id_escreve;
    logic          id_ex_bolha;
    logic [CW-1:0] contador_stalls;

    unidade_hazard #(.REG_BITS(RB), .CONT_WIDTH(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valido       (id_valido),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_usa_rs1      (id_usa_rs1),
        .id_usa_rs2      (id_usa_rs2),
        .id_rd           (id_rd),
        .id_escreve_reg  (id_escreve_reg),
        .id_le_mem       (id_le_mem),
        .flush_ex        (flush_ex),
        .seletor_a       (seletor_a),
        .seletor_b       (seletor_b),
        .stall           (stall),
        .pc_escreve      (pc_escreve),
        .if_id_escreve   (if_id_escreve),
        .id_ex_bolha     (id_ex_bolha),
        .contador_stalls (contador_stalls)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        bit v;
        int rs1;
        int rs2;
        bit u1;
        bit u2;
        int rd;
        bit w;
        bit ld;
    } ins_t;

    ins_t hist[$];     // [0]=EX, [1]=MEM, [2]=WB
    ins_t cur;         // instruction driven into ID
    bit   cur_flush;
    int   n_stalls;    // unsaturated stall count since reset
    int   total = 0;
    int   bad   = 0;

    function automatic ins_t mk(bit v, int rs1, int rs2, bit u1, bit u2, int rd, bit w, bit ld);
        ins_t i;
        i.v = v; i.rs1 = rs1; i.rs2 = rs2; i.u1 = u1; i.u2 = u2;
        i.rd = rd; i.w = w; i.ld = ld;
        return i;
    endfunction

    function automatic ins_t nop();
        return mk(0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic bit produces(ins_t p, int r);
        return p.v && p.w && (p.rd != 0) && (p.rd == r);
    endfunction

    // which = 0 -> operand A (rs1), 1 -> operand B (rs2)
    function automatic logic [1:0] exp_sel(int which);
        ins_t e;
        int   r;
        e = hist[0];
        if (!e.v || !(which ? e.u2 : e.u1)) return 2'b00;
        r = which ? e.rs2 : e.rs1;
        if (produces(hist[1], r) && !hist[1].ld) return 2'b10;
        if (produces(hist[2], r)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic exp_stall();
        ins_t e;
        e = hist[0];
        return cur.v && e.v && e.ld && (e.rd != 0) && !cur_flush &&
               ((cur.u1 && cur.rs1 == e.rd) || (cur.u2 && cur.rs2 == e.rd));
    endfunction

    function automatic logic [CW-1:0] exp_cnt();
        return (n_stalls >= (1 << CW) - 1) ? {CW{1'b1}} : CW'(n_stalls);
    endfunction

    task automatic clear_model();
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back(nop());
        n_stalls = 0;
    endtask

    task automatic set_id(ins_t i, bit fl);
        cur            = i;
        cur_flush      = fl;
        id_valido      = i.v;
        id_rs1         = i.rs1[RB-1:0];
        id_rs2         = i.rs2[RB-1:0];
        id_usa_rs1     = i.u1;
        id_usa_rs2     = i.u2;
        id_rd          = i.rd[RB-1:0];
        id_escreve_reg = i.w;
        id_le_mem      = i.ld;
        flush_ex       = fl;
    endtask

    // One clock edge; the model advances the same way the pipeline does.
    task automatic advance();
        bit st;
        st = exp_stall();
        if (st) n_stalls++;
        hist.push_front((st || cur_flush) ? nop() : cur);
        void'(hist.pop_back());
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        set_id(mk(1, 8, 8, 1, 1, 9, 1, 0), 1'b0);
        rst_n = 1'b0;
        clear_model();
        #2;
        total++; if (seletor_a !== 2'b00) begin bad++; $display("FAIL reset_sel_a: got %b want 00", seletor_a); end
        total++; if (stall !== 1'b0 || pc_escreve !== 1'b1 || if_id_escreve !== 1'b1 || id_ex_bolha !== 1'b0) begin
            bad++; $display("FAIL reset_ctrl: stall=%b pc=%b ifid=%b bolha=%b want 0 1 1 0",
                            stall, pc_escreve, if_id_escreve, id_ex_bolha);
        end
        total++; if (contador_stalls !== '0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", contador_stalls); end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Build one counted stall, then a second pending stall, and reset mid-stall.
        set_id(mk(1, 1, 0, 1, 0, 8, 1, 1), 1'b0); advance();
        set_id(mk(1, 8, 8, 1, 1, 9, 1, 0), 1'b0); advance();
        set_id(mk(1, 1, 0, 1, 0, 3, 1, 1), 1'b0); advance();
        set_id(mk(1, 3, 2, 1, 1, 4, 1, 0), 1'b0);
        #1;
        total++; if (stall !== 1'b1 || contador_stalls !== 4'd1) begin
            bad++; $display("FAIL pre_reset: stall=%b cnt=%0d want 1 1", stall, contador_stalls);
        end
        rst_n = 1'b0;
        #1;
        total++; if (stall !== 1'b0 || pc_escreve !== 1'b1 || id_ex_bolha !== 1'b0 ||
                     seletor_a !== 2'b00 || seletor_b !== 2'b00 || contador_stalls !== '0) begin
            bad++; $display("FAIL async_reset: stall=%b pc=%b bolha=%b sa=%b sb=%b cnt=%0d want 0 1 0 00 00 0",
                            stall, pc_escreve, id_ex_bolha, seletor_a, seletor_b, contador_stalls);
        end
        clear_model();
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL held_after_reset: stall got %b want 0", stall); end
    endtask

    task automatic test_fwd_exmem();
        set_id(mk(1, 1, 2, 1, 1, 5, 1, 0), 1'b0); advance();   // add x5,x1,x2
        set_id(mk(1, 5, 1, 1, 1, 6, 1, 0), 1'b0); advance();   // sub x6,x5,x1
        set_id(nop(), 1'b0);
        #1;
        total++; if (seletor_a !== 2'b10) begin bad++; $display("FAIL exmem_sel_a: got %b want 10", seletor_a); end
        total++; if (seletor_b !== 2'b00) begin bad++; $display("FAIL exmem_sel_b: got %b want 00", seletor_b); end
    endtask

    task automatic test_fwd_memwb();
        set_id(mk(1, 1, 2, 1, 1, 5, 1, 0), 1'b0); advance();   // add x5,x1,x2
        set_id(nop(), 1'b0);                      advance();
        set_id(mk(1, 1, 5, 1, 1, 7, 1, 0), 1'b0); advance();   // or x7,x1,x5
        set_id(nop(), 1'b0);
        #1;
        total++; if (seletor_b !== 2'b01 || seletor_a !== 2'b00) begin
            bad++; $display("FAIL memwb_sel: a=%b b=%b want 00 01", seletor_a, seletor_b);
        end
        set_id(mk(1, 1, 2, 1, 1, 5, 1, 0), 1'b0); advance();   // add x5,x1,x2
        set_id(mk(1, 3, 4, 1, 1, 5, 1, 0), 1'b0); advance();   // add x5,x3,x4
        set_id(mk(1, 5, 1, 1, 1, 7, 1, 0), 1'b0); advance();   // or x7,x5,x1
        set_id(nop(), 1'b0);
        #1;
        total++; if (seletor_a !== 2'b10) begin bad++; $display("FAIL mem_beats_wb: got %b want 10", seletor_a); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(mk(1, 1, 0, 1, 0, 8, 1, 1), 1'b0); advance();   // lw x8,0(x1)
        set_id(mk(1, 8, 8, 1, 1, 9, 1, 0), 1'b0);              // add x9,x8,x8
        #1;
        total++; if (stall !== 1'b1 || pc_escreve !== 1'b0 || if_id_escreve !== 1'b0 || id_ex_bolha !== 1'b1) begin
            bad++; $display("FAIL load_use: stall=%b pc=%b ifid=%b bolha=%b want 1 0 0 1",
                            stall, pc_escreve, if_id_escreve, id_ex_bolha);
        end
        advance();                                             // add held in ID
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL stall_one_cycle: got %b want 0", stall); end
        advance();
        set_id(nop(), 1'b0);
        #1;
        total++; if (seletor_a !== 2'b01 || seletor_b !== 2'b01) begin
            bad++; $display("FAIL load_fwd: a=%b b=%b want 01 01", seletor_a, seletor_b);
        end
        total++; if (contador_stalls !== 4'd1) begin bad++; $display("FAIL load_cnt: got %0d want 1", contador_stalls); end
    endtask

    task automatic test_flush_priority();
        do_reset();
        set_id(mk(1, 1, 0, 1, 0, 8, 1, 1), 1'b0); advance();
        set_id(mk(1, 8, 8, 1, 1, 9, 1, 0), 1'b1);
        #1;
        total++; if (stall !== 1'b0 || id_ex_bolha !== 1'b1 || pc_escreve !== 1'b1) begin
            bad++; $display("FAIL flush_prio: stall=%b bolha=%b pc=%b want 0 1 1", stall, id_ex_bolha, pc_escreve);
        end
        advance();
        set_id(nop(), 1'b0);
        #1;
        total++; if (contador_stalls !== 4'd0) begin bad++; $display("FAIL flush_cnt: got %0d want 0", contador_stalls); end
    endtask

    task automatic test_x0_and_saturation();
        set_id(mk(1, 0, 0, 1, 0, 0, 1, 0), 1'b0); advance();   // addi x0,x0,1
        set_id(mk(1, 0, 0, 1, 1, 2, 1, 0), 1'b0); advance();   // add x2,x0,x0
        set_id(nop(), 1'b0);
        #1;
        total++; if (seletor_a !== 2'b00 || seletor_b !== 2'b00) begin
            bad++; $display("FAIL x0_fwd: a=%b b=%b want 00 00", seletor_a, seletor_b);
        end
        do_reset();
        for (int k = 0; k < 18; k++) begin
            set_id(mk(1, 1, 0, 1, 0, 8, 1, 1), 1'b0); advance();
            set_id(mk(1, 8, 8, 1, 1, 9, 1, 0), 1'b0); advance();
            set_id(nop(), 1'b0);                      advance();
        end
        total++; if (contador_stalls !== 4'hF) begin bad++; $display("FAIL saturate: got %h want F", contador_stalls); end
        set_id(mk(1, 1, 0, 1, 0, 8, 1, 1), 1'b0); advance();
        set_id(mk(1, 8, 8, 1, 1, 9, 1, 0), 1'b0);
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL sat_stall: got %b want 1", stall); end
        advance();
        total++; if (contador_stalls !== 4'hF) begin bad++; $display("FAIL no_wrap: got %h want F", contador_stalls); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            ins_t i;
            if ($urandom_range(0, 79) == 0) do_reset();
            i = mk($urandom_range(0, 9) != 0,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                   int'($urandom_range(0, 3)), $urandom_range(0, 4) != 0,
                   $urandom_range(0, 2) == 0);
            set_id(i, $urandom_range(0, 9) == 0);
            #1;
            total++; if (seletor_a !== exp_sel(0) || seletor_b !== exp_sel(1)) begin
                bad++; $display("FAIL rnd_sel[%0d]: a=%b b=%b want %b %b", n, seletor_a, seletor_b, exp_sel(0), exp_sel(1));
            end
            total++; if (stall !== exp_stall() || pc_escreve !== !exp_stall() || if_id_escreve !== !exp_stall() ||
                         id_ex_bolha !== (exp_stall() || cur_flush)) begin
                bad++; $display("FAIL rnd_ctrl[%0d]: stall=%b pc=%b ifid=%b bolha=%b want stall=%b flush=%b",
                                n, stall, pc_escreve, if_id_escreve, id_ex_bolha, exp_stall(), cur_flush);
            end
            total++; if (contador_stalls !== exp_cnt()) begin
                bad++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", n, contador_stalls, exp_cnt());
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_fwd_exmem();
        test_fwd_memwb();
        test_load_use();
        test_flush_priority();
        test_x0_and_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
